// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life sequencer.
package life_pkg;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } life_state_e;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned ROW_W = 3;

  // Next seed row index, wrapping from the last row back to row 0.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    return (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
  endfunction

endpackage

// File: rtl/life_controller_gen_tick.sv
// Generation pacing divider: counts 0..TICK_DIV-1 while enabled.
module gen_tick #(
  parameter  int unsigned TICK_DIV = 25_000_000,
  localparam int unsigned TICK_W   = $clog2(TICK_DIV)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [TICK_W-1:0] tick,
  output logic              wrap_c
);

  // Last count of the period while enabled.
  assign wrap_c = en && (tick == TICK_W'(TICK_DIV - 1));

  // Divider counter; clear wins over enable, holds when disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
    end else if (clr) begin
      tick <= '0;
    end else if (en) begin
      tick <= wrap_c ? '0 : tick + TICK_W'(1);
    end
  end

endmodule

// File: rtl/life_controller.sv
// Top-level sequencer: seed entry, generation pacing, pause/resume, clear, halt.
module life_controller
  import life_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned GEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next,
  input  logic             start,
  input  logic             clear,
  input  logic             alive,
  output logic             seed_we,
  output logic [ROW_W-1:0] seed_row,
  output logic             step,
  output logic             board_clr,
  output logic [GEN_W-1:0] gen_count,
  output life_state_e      state
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  logic              next_q;
  logic              start_q;
  logic [TICK_W-1:0] tick;
  logic              wrap_c;
  logic              tick_en_c;
  logic              tick_clr_c;
  logic              next_rise_c;
  logic              start_fall_c;
  logic              alive_chk_c;

  assign next_rise_c  = next & ~next_q;
  assign start_fall_c = start_q & ~start;

  // Tick only advances in RUN; it is held at zero in SEED so every run starts fresh.
  assign tick_en_c  = (state == RUN);
  assign tick_clr_c = clear || (state == SEED);

  // Board population is meaningful one cycle after the datapath consumed a step.
  assign alive_chk_c = (tick == TICK_W'(1)) && (gen_count != '0);

  gen_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_gen_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (tick_en_c),
    .clr    (tick_clr_c),
    .tick   (tick),
    .wrap_c (wrap_c)
  );

  // Sequencer state, row/generation counters and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEED;
      seed_row  <= '0;
      gen_count <= '0;
      seed_we   <= 1'b0;
      step      <= 1'b0;
      board_clr <= 1'b0;
      next_q    <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      next_q    <= next;
      start_q   <= start;
      seed_we   <= 1'b0;
      step      <= 1'b0;
      board_clr <= 1'b0;

      // Row index advances only after the write strobe has been presented with it.
      if (seed_we) begin
        seed_row <= next_row(seed_row);
      end

      if (clear) begin
        board_clr <= 1'b1;
        state     <= SEED;
        seed_row  <= '0;
        gen_count <= '0;
      end else begin
        case (state)
          SEED: begin
            if (next_rise_c) begin
              seed_we <= 1'b1;
            end
            if (start) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (wrap_c) begin
              step <= 1'b1;
              if (gen_count != '1) begin
                gen_count <= gen_count + GEN_W'(1);
              end
            end
            if (alive_chk_c && !alive) begin
              state <= HALT;
            end else if (!start) begin
              state <= PAUSE;
            end
          end
          PAUSE: begin
            if (start) begin
              state <= RUN;
            end
          end
          HALT: begin
            if (start_fall_c) begin
              state    <= SEED;
              seed_row <= '0;
            end
          end
          default: begin
            state <= SEED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller with a strobe scoreboard.
module tb_life_controller;
  import life_pkg::*;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned GEN_W    = 8;

  logic             clk;
  logic             reset;
  logic             next;
  logic             start;
  logic             clear;
  logic             alive;
  logic             seed_we;
  logic [ROW_W-1:0] seed_row;
  logic             step;
  logic             board_clr;
  logic [GEN_W-1:0] gen_count;
  life_state_e      state;

  int total = 0;
  int bad   = 0;

  int q_we[$];
  int q_step[$];
  int q_clr[$];

  life_controller #(
    .TICK_DIV (TICK_DIV),
    .GEN_W    (GEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .start     (start),
    .clear     (clear),
    .alive     (alive),
    .seed_we   (seed_we),
    .seed_row  (seed_row),
    .step      (step),
    .board_clr (board_clr),
    .gen_count (gen_count),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    next = 1'b1;
    cyc(1);
    next = 1'b0;
    cyc(1);
  endtask

  // Scoreboard: every strobe must match the oldest expectation of its kind.
  always @(negedge clk) begin
    if (reset) begin
      chk("strobe_exclusive", 32'({seed_we, step, board_clr} inside {3'b000, 3'b001, 3'b010, 3'b100}), 32'(1));
      if (seed_we) begin
        if (q_we.size() == 0) chk("seed_we_unexpected", 32'(seed_we), 32'(0));
        else chk("seed_row_at_we", 32'(seed_row), 32'(q_we.pop_front()));
      end
      if (step) begin
        if (q_step.size() == 0) chk("step_unexpected", 32'(step), 32'(0));
        else chk("gen_at_step", 32'(gen_count), 32'(q_step.pop_front()));
      end
      if (board_clr) begin
        if (q_clr.size() == 0) chk("board_clr_unexpected", 32'(board_clr), 32'(0));
        else chk("gen_at_clr", 32'(gen_count), 32'(q_clr.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    next  = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    alive = 1'b1;
    cyc(2);
    chk("rst_state", 32'(state), 32'(SEED));
    chk("rst_row", 32'(seed_row), 32'(0));
    chk("rst_gen", 32'(gen_count), 32'(0));
    chk("rst_strobes", 32'({seed_we, step, board_clr}), 32'(0));
    reset = 1'b1;
    cyc(1);

    // Seed wrap: nine presses write rows 0..7 then 0.
    for (int i = 0; i < 9; i++) begin
      q_we.push_back(i % 8);
      press();
    end
    chk("seed_wrap_row", 32'(seed_row), 32'(1));
    chk("seed_wrap_state", 32'(state), 32'(SEED));

    // Run cadence: five steps in twenty cycles after entering RUN.
    for (int g = 1; g <= 5; g++) q_step.push_back(g);
    start = 1'b1;
    cyc(21);
    chk("run_gen", 32'(gen_count), 32'(5));
    chk("run_state", 32'(state), 32'(RUN));

    // Pause at tick==2, resume ten cycles later.
    cyc(2);
    start = 1'b0;
    cyc(10);
    chk("pause_state", 32'(state), 32'(PAUSE));
    chk("pause_gen", 32'(gen_count), 32'(5));
    q_step.push_back(6);
    start = 1'b1;
    cyc(1);
    chk("resume_state", 32'(state), 32'(RUN));
    chk("resume_no_step", 32'(step), 32'(0));
    cyc(1);
    chk("resume_step", 32'(step), 32'(1));
    chk("resume_gen", 32'(gen_count), 32'(6));

    // Clear in RUN with a coincident next rise.
    q_clr.push_back(0);
    next  = 1'b1;
    clear = 1'b1;
    start = 1'b0;
    cyc(1);
    chk("clr_run_pulse", 32'(board_clr), 32'(1));
    chk("clr_run_we", 32'(seed_we), 32'(0));
    chk("clr_run_state", 32'(state), 32'(SEED));
    chk("clr_run_row", 32'(seed_row), 32'(0));
    clear = 1'b0;
    next  = 1'b0;
    cyc(1);
    chk("clr_run_single", 32'(board_clr), 32'(0));

    // Extinction after the third step.
    for (int g = 1; g <= 3; g++) q_step.push_back(g);
    start = 1'b1;
    cyc(13);
    chk("ext_step3", 32'(step), 32'(1));
    chk("ext_gen3", 32'(gen_count), 32'(3));
    alive = 1'b0;
    cyc(2);
    chk("ext_halt", 32'(state), 32'(HALT));
    cyc(8);
    chk("ext_halt_hold", 32'(state), 32'(HALT));
    chk("ext_gen_frozen", 32'(gen_count), 32'(3));
    start = 1'b0;
    cyc(1);
    chk("ext_back_seed", 32'(state), 32'(SEED));
    chk("ext_keep_gen", 32'(gen_count), 32'(3));
    chk("ext_row", 32'(seed_row), 32'(0));
    alive = 1'b1;

    // Clear in SEED with a coincident next rise.
    q_we.push_back(0);
    press();
    chk("pre_clr_row", 32'(seed_row), 32'(1));
    q_clr.push_back(0);
    next  = 1'b1;
    clear = 1'b1;
    cyc(1);
    chk("clr_seed_pulse", 32'(board_clr), 32'(1));
    chk("clr_seed_we", 32'(seed_we), 32'(0));
    chk("clr_seed_row", 32'(seed_row), 32'(0));
    chk("clr_seed_gen", 32'(gen_count), 32'(0));
    chk("clr_seed_state", 32'(state), 32'(SEED));
    clear = 1'b0;
    next  = 1'b0;
    cyc(2);
    chk("clr_seed_no_we", 32'(seed_we), 32'(0));

    // Start with a coincident press: the write lands in the first RUN cycle.
    q_we.push_back(0);
    q_step.push_back(1);
    next  = 1'b1;
    start = 1'b1;
    cyc(1);
    chk("coinc_we", 32'(seed_we), 32'(1));
    chk("coinc_state", 32'(state), 32'(RUN));
    next = 1'b0;
    cyc(4);
    chk("coinc_step", 32'(step), 32'(1));
    chk("coinc_gen", 32'(gen_count), 32'(1));

    // Async reset mid-RUN with next held high.
    next = 1'b1;
    cyc(2);
    chk("run_ignores_next", 32'(seed_we), 32'(0));
    #3;
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(SEED));
    chk("arst_gen", 32'(gen_count), 32'(0));
    chk("arst_row", 32'(seed_row), 32'(0));
    chk("arst_strobes", 32'({seed_we, step, board_clr}), 32'(0));
    start = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(4);
    chk("arst_held_no_we", 32'(seed_we), 32'(0));
    chk("arst_held_state", 32'(state), 32'(SEED));
    next = 1'b0;
    cyc(1);
    q_we.push_back(0);
    next = 1'b1;
    cyc(1);
    chk("arst_toggle_we", 32'(seed_we), 32'(1));
    next = 1'b0;
    cyc(2);

    chk("q_we_drained", 32'(q_we.size()), 32'(0));
    chk("q_step_drained", 32'(q_step.size()), 32'(0));
    chk("q_clr_drained", 32'(q_clr.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
